alu_seq: RTL and testbench

//  Parametrised multi-cycle ALU: single-cycle logic/arith ops plus iterative multiply and (optional) divide.

---
 rtl/alu_seq_pkg.sv | 24 ++
 rtl/alu_seq_if.sv | 28 ++
 rtl/alu_seq_muldiv.sv | 77 +++++++
 rtl/alu_seq.sv | 156 +++++++++++++++
 tb/tb_alu_seq.sv | 271 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_seq_pkg.sv
// Shared opcodes, FSM state encoding and widths for the sequential ALU.
// The divider is present only when ALU_SEQ_DIV_EN is defined.
package alu_seq_pkg;

   localparam int unsigned OP_W = 4;

   localparam logic [OP_W-1:0] OP_AND   = 4'b0000;
   localparam logic [OP_W-1:0] OP_OR    = 4'b0001;
   localparam logic [OP_W-1:0] OP_ADD   = 4'b0010;
   localparam logic [OP_W-1:0] OP_SUB   = 4'b0110;
   localparam logic [OP_W-1:0] OP_SLT   = 4'b0111;
   localparam logic [OP_W-1:0] OP_MUL   = 4'b1000;
   localparam logic [OP_W-1:0] OP_MULHU = 4'b1001;
   localparam logic [OP_W-1:0] OP_DIVU  = 4'b1010;
   localparam logic [OP_W-1:0] OP_REMU  = 4'b1011;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_MUL  = 2'd1,
      S_DIV  = 2'd2,
      S_DONE = 2'd3
   } state_e;

endpackage

// File: rtl/alu_seq_if.sv
// Issue/result handshake bundle between the control unit (master) and the ALU (slave).
interface alu_seq_if
   import alu_seq_pkg::*;
#(
   parameter int unsigned WIDTH = 32
);
   logic             in_valid_i;
   logic             in_ready_o;
   logic [OP_W-1:0]  op_i;
   logic [WIDTH-1:0] src1_i;
   logic [WIDTH-1:0] src2_i;
   logic             out_valid_o;
   logic             out_ready_i;
   logic [WIDTH-1:0] result_o;
   logic             zero_o;
   logic             ovf_o;
   logic             err_o;

   modport slave (
      input  in_valid_i, op_i, src1_i, src2_i, out_ready_i,
      output in_ready_o, out_valid_o, result_o, zero_o, ovf_o, err_o
   );

   modport master (
      output in_valid_i, op_i, src1_i, src2_i, out_ready_i,
      input  in_ready_o, out_valid_o, result_o, zero_o, ovf_o, err_o
   );
endinterface

// File: rtl/alu_seq_muldiv.sv
// Iterative shift datapath: shift-add multiply and (with ALU_SEQ_DIV_EN) restoring divide,
// one bit per cycle over WIDTH cycles; hi_c/lo_c expose the value after the current step.
module alu_seq_muldiv #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             is_div,
   input  logic [WIDTH-1:0] src1,
   input  logic [WIDTH-1:0] src2,
   output logic             busy,
   output logic             done_c,
   output logic [WIDTH-1:0] hi_c,
   output logic [WIDTH-1:0] lo_c
);
   localparam int unsigned CNT_W = $clog2(WIDTH) + 1;
   localparam int unsigned AW    = 2 * WIDTH;

   logic [AW-1:0]    acc_q;
   logic [WIDTH-1:0] opb_q;
   logic [CNT_W-1:0] cnt_q;
   logic             busy_q;
   logic [AW-1:0]    step_c;

   // Multiply: acc = {partial sum, multiplier}; add multiplicand on LSB then shift right.
   logic [WIDTH:0]   mul_sum_c;
   logic [AW-1:0]    mul_nxt_c;
   assign mul_sum_c = {1'b0, acc_q[AW-1:WIDTH]} + (acc_q[0] ? {1'b0, opb_q} : '0);
   assign mul_nxt_c = {mul_sum_c, acc_q[WIDTH-1:1]};

`ifdef ALU_SEQ_DIV_EN
   // Divide: acc = {remainder, dividend/quotient}; shift left, keep the trial subtract if >= 0.
   logic             div_q;
   logic [WIDTH:0]   div_rs_c;
   logic [WIDTH:0]   div_diff_c;
   logic [AW-1:0]    div_nxt_c;
   assign div_rs_c   = acc_q[AW-1:WIDTH-1];
   assign div_diff_c = div_rs_c - {1'b0, opb_q};
   assign div_nxt_c  = div_diff_c[WIDTH]
                       ? {div_rs_c[WIDTH-1:0],   acc_q[WIDTH-2:0], 1'b0}
                       : {div_diff_c[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
   assign step_c     = div_q ? div_nxt_c : mul_nxt_c;
`else
   assign step_c     = mul_nxt_c;
`endif

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         acc_q  <= '0;
         opb_q  <= '0;
         cnt_q  <= '0;
         busy_q <= 1'b0;
`ifdef ALU_SEQ_DIV_EN
         div_q  <= 1'b0;
`endif
      end else if (start) begin
         acc_q  <= {{WIDTH{1'b0}}, (is_div ? src1 : src2)};
         opb_q  <= is_div ? src2 : src1;
         cnt_q  <= CNT_W'(WIDTH - 1);
         busy_q <= 1'b1;
`ifdef ALU_SEQ_DIV_EN
         div_q  <= is_div;
`endif
      end else if (busy_q) begin
         acc_q <= step_c;
         cnt_q <= cnt_q - CNT_W'(1);
         if (cnt_q == '0) busy_q <= 1'b0;
      end
   end

   assign busy   = busy_q;
   assign done_c = busy_q & (cnt_q == '0);
   assign hi_c   = step_c[AW-1:WIDTH];
   assign lo_c   = step_c[WIDTH-1:0];

endmodule

// File: rtl/alu_seq.sv
// Multi-cycle ALU top: valid/ready handshake FSM, single-cycle ops and result flags.
// Define ALU_SEQ_DIV_EN to enable DIVU/REMU; otherwise those opcodes report illegal.
module alu_seq
   import alu_seq_pkg::*;
#(
   parameter int unsigned WIDTH = 32
) (
   input logic       clk,
   input logic       rst_n,
   alu_seq_if.slave  bus
);
   localparam int unsigned MSB = WIDTH - 1;

   state_e           state_q, state_d;
   logic [OP_W-1:0]  op_q;
   logic             in_ready_q, out_valid_q, zero_q, ovf_q, err_q;
   logic [WIDTH-1:0] result_q;

   logic             in_ready_d, out_valid_d, ovf_d, err_d;
   logic [WIDTH-1:0] result_d;

   logic             accept_c, is_mul_c, is_div_c, div_zero_c, start_c;
   logic [WIDTH-1:0] add_c, sub_c;
   logic             add_ovf_c, sub_ovf_c, slt_c;
   logic             md_busy, md_done_c;
   logic [WIDTH-1:0] md_hi_c, md_lo_c;

   assign accept_c = bus.in_valid_i & in_ready_q;
   assign is_mul_c = (bus.op_i == OP_MUL) | (bus.op_i == OP_MULHU);
`ifdef ALU_SEQ_DIV_EN
   assign is_div_c = (bus.op_i == OP_DIVU) | (bus.op_i == OP_REMU);
`else
   assign is_div_c = 1'b0;
`endif
   assign div_zero_c = is_div_c & (bus.src2_i == '0);
   assign start_c    = accept_c & (is_mul_c | (is_div_c & ~div_zero_c));

   assign add_c     = bus.src1_i + bus.src2_i;
   assign sub_c     = bus.src1_i - bus.src2_i;
   assign add_ovf_c = (bus.src1_i[MSB] == bus.src2_i[MSB]) & (add_c[MSB] != bus.src1_i[MSB]);
   assign sub_ovf_c = (bus.src1_i[MSB] != bus.src2_i[MSB]) & (sub_c[MSB] != bus.src1_i[MSB]);
   assign slt_c     = $signed(bus.src1_i) < $signed(bus.src2_i);

   alu_seq_muldiv #(.WIDTH(WIDTH)) u_muldiv (
      .clk    (clk),
      .rst_n  (rst_n),
      .start  (start_c),
      .is_div (is_div_c),
      .src1   (bus.src1_i),
      .src2   (bus.src2_i),
      .busy   (md_busy),
      .done_c (md_done_c),
      .hi_c   (md_hi_c),
      .lo_c   (md_lo_c)
   );

   // State register
   always_ff @(posedge clk) begin
      if (!rst_n) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE: begin
            if (accept_c) begin
               if (is_mul_c)                    state_d = S_MUL;
               else if (is_div_c & ~div_zero_c) state_d = S_DIV;
               else                             state_d = S_DONE;
            end
         end
         S_MUL, S_DIV: begin
            if (md_done_c)     state_d = S_DONE;
            else if (!md_busy) state_d = S_IDLE;   // unreachable recovery if the datapath drops out
         end
         S_DONE: begin
            if (bus.out_ready_i) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Next values of the registered outputs
   always_comb begin
      out_valid_d = out_valid_q;
      result_d    = result_q;
      ovf_d       = ovf_q;
      err_d       = err_q;
      in_ready_d  = (state_d == S_IDLE);
      unique case (state_q)
         S_IDLE: begin
            if (accept_c & ~start_c) begin
               out_valid_d = 1'b1;
               result_d    = '0;
               ovf_d       = 1'b0;
               err_d       = 1'b0;
               case (bus.op_i)
                  OP_ADD: begin result_d = add_c; ovf_d = add_ovf_c; end
                  OP_SUB: begin result_d = sub_c; ovf_d = sub_ovf_c; end
                  OP_AND: result_d = bus.src1_i & bus.src2_i;
                  OP_OR:  result_d = bus.src1_i | bus.src2_i;
                  OP_SLT: result_d = {{(WIDTH-1){1'b0}}, slt_c};
`ifdef ALU_SEQ_DIV_EN
                  OP_DIVU: begin result_d = '1;         err_d = 1'b1; end
                  OP_REMU: begin result_d = bus.src1_i; err_d = 1'b1; end
`endif
                  default: err_d = 1'b1;
               endcase
            end
         end
         S_MUL, S_DIV: begin
            if (md_done_c) begin
               out_valid_d = 1'b1;
               ovf_d       = 1'b0;
               err_d       = 1'b0;
               result_d    = ((op_q == OP_MULHU) | (op_q == OP_REMU)) ? md_hi_c : md_lo_c;
            end
         end
         S_DONE: begin
            if (bus.out_ready_i) out_valid_d = 1'b0;
         end
         default: out_valid_d = 1'b0;
      endcase
   end

   // Output and opcode registers
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         result_q    <= '0;
         zero_q      <= 1'b1;
         ovf_q       <= 1'b0;
         err_q       <= 1'b0;
         op_q        <= '0;
      end else begin
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
         result_q    <= result_d;
         zero_q      <= (result_d == '0);
         ovf_q       <= ovf_d;
         err_q       <= err_d;
         if (accept_c) op_q <= bus.op_i;
      end
   end

   assign bus.in_ready_o  = in_ready_q;
   assign bus.out_valid_o = out_valid_q;
   assign bus.result_o    = result_q;
   assign bus.zero_o      = zero_q;
   assign bus.ovf_o       = ovf_q;
   assign bus.err_o       = err_q;

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: arithmetic reference model plus directed vectors.
module tb_alu_seq;
   import alu_seq_pkg::*;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   alu_seq_if #(.WIDTH(32)) bus ();

   alu_seq #(.WIDTH(32)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   typedef struct {
      logic [31:0] res;
      logic        zero;
      logic        ovf;
      logic        err;
      int          lat;
   } exp_t;

   exp_t        exp_q[$];
   exp_t        cur;
   bit          have_cur = 1'b0;
   bit          first    = 1'b0;
   int          ncyc     = 0;
   int          acc_n    = 0;
   int          checks   = 0;
   int          errors   = 0;
   logic [31:0] last_res = '0;
   logic        last_zero = 1'b0, last_ovf = 1'b0, last_err = 1'b0;
   int          last_lat = 0;

   // Reference: plain integer arithmetic on the operands.
   function automatic exp_t model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      exp_t        e;
      longint      s;
      logic [63:0] p;
      e.res = '0; e.ovf = 1'b0; e.err = 1'b0; e.lat = 1;
      p = {32'b0, a} * {32'b0, b};
      case (op)
         OP_ADD: begin
            e.res = a + b;
            s = longint'($signed(a)) + longint'($signed(b));
            e.ovf = (s != longint'($signed(e.res)));
         end
         OP_SUB: begin
            e.res = a - b;
            s = longint'($signed(a)) - longint'($signed(b));
            e.ovf = (s != longint'($signed(e.res)));
         end
         OP_AND:   e.res = a & b;
         OP_OR:    e.res = a | b;
         OP_SLT:   e.res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         OP_MUL:   begin e.res = p[31:0];  e.lat = 33; end
         OP_MULHU: begin e.res = p[63:32]; e.lat = 33; end
`ifdef ALU_SEQ_DIV_EN
         OP_DIVU: begin
            if (b == 0) begin e.res = 32'hFFFF_FFFF; e.err = 1'b1; end
            else        begin e.res = a / b; e.lat = 33; end
         end
         OP_REMU: begin
            if (b == 0) begin e.res = a; e.err = 1'b1; end
            else        begin e.res = a % b; e.lat = 33; end
         end
`endif
         default: e.err = 1'b1;
      endcase
      e.zero = (e.res == 0);
      return e;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s actual=0x%0h required=0x%0h", name, act, expv);
      end
   endtask

   task automatic bound_fail(input string name);
      checks++;
      errors++;
      $display("FAIL %s actual=timeout required=event", name);
   endtask

   // Compare process: every cycle out of reset, against the model entry for the accepted op.
   always @(negedge clk) begin
      ncyc++;
      if (!rst_n) begin
         have_cur = 1'b0;
      end else begin
         chk("in_ready", 64'(bus.in_ready_o), 64'(!have_cur));
         if (bus.out_valid_o) begin
            if (!have_cur) begin
               checks++;
               errors++;
               $display("FAIL unexpected_valid actual=1 required=0");
            end else begin
               chk("result", 64'(bus.result_o), 64'(cur.res));
               chk("zero",   64'(bus.zero_o),   64'(cur.zero));
               chk("ovf",    64'(bus.ovf_o),    64'(cur.ovf));
               chk("err",    64'(bus.err_o),    64'(cur.err));
               if (first) begin
                  last_lat = ncyc - acc_n;
                  chk("latency", 64'(last_lat), 64'(cur.lat));
                  first = 1'b0;
               end
               if (bus.out_ready_i) begin
                  last_res  = bus.result_o;
                  last_zero = bus.zero_o;
                  last_ovf  = bus.ovf_o;
                  last_err  = bus.err_o;
                  have_cur  = 1'b0;
               end
            end
         end
         if (bus.in_valid_i && bus.in_ready_o) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_accept actual=1 required=0");
            end else begin
               cur      = exp_q.pop_front();
               have_cur = 1'b1;
               first    = 1'b1;
               acc_n    = ncyc;
            end
         end
      end
   end

   task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      bit ok = 1'b0;
      @(posedge clk); #1;
      exp_q.push_back(model(op, a, b));
      bus.op_i = op; bus.src1_i = a; bus.src2_i = b; bus.in_valid_i = 1'b1;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (bus.in_ready_o) begin ok = 1'b1; break; end
      end
      if (!ok) bound_fail("accept_timeout");
      @(posedge clk); #1;
      bus.in_valid_i = 1'b0;
   endtask

   task automatic wait_done();
      bit ok = 1'b0;
      for (int i = 0; i < 200; i++) begin
         @(posedge clk); #1;
         if (!have_cur && exp_q.size() == 0) begin ok = 1'b1; break; end
      end
      if (!ok) bound_fail("done_timeout");
   endtask

   task automatic run(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      issue(op, a, b);
      wait_done();
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bit ok;
      rst_n = 1'b0;
      bus.in_valid_i = 1'b0; bus.op_i = '0; bus.src1_i = '0; bus.src2_i = '0;
      bus.out_ready_i = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_in_ready",  64'(bus.in_ready_o),  64'd1);
      chk("rst_out_valid", 64'(bus.out_valid_o), 64'd0);
      chk("rst_result",    64'(bus.result_o),    64'd0);
      chk("rst_zero",      64'(bus.zero_o),      64'd1);
      chk("rst_ovf",       64'(bus.ovf_o),       64'd0);
      chk("rst_err",       64'(bus.err_o),       64'd0);
      @(posedge clk); #1 rst_n = 1'b1;

      run(OP_ADD, 32'h7FFF_FFFF, 32'h1);
      chk("add_ovf_res", 64'(last_res), 64'h8000_0000);
      chk("add_ovf_flag", 64'(last_ovf), 64'd1);
      chk("add_lat", 64'(last_lat), 64'd1);
      run(OP_ADD, 32'h8000_0000, 32'h8000_0000);
      run(OP_SUB, 32'd5, 32'd5);
      chk("sub_zero_res", 64'(last_res), 64'd0);
      chk("sub_zero_flag", 64'(last_zero), 64'd1);
      run(OP_SUB, 32'h8000_0000, 32'h1);
      run(OP_AND, 32'hF0F0_1234, 32'h0FF0_FF00);
      run(OP_OR,  32'hF0F0_1234, 32'h0FF0_FF00);
      run(OP_SLT, 32'hFFFF_FFFF, 32'd1);
      chk("slt_neg_pos", 64'(last_res), 64'd1);
      run(OP_SLT, 32'd1, 32'hFFFF_FFFF);
      chk("slt_pos_neg", 64'(last_res), 64'd0);
      run(OP_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      chk("mul_lo", 64'(last_res), 64'd1);
      chk("mul_lat", 64'(last_lat), 64'd33);
      run(OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      chk("mulhu", 64'(last_res), 64'hFFFF_FFFE);
      run(OP_MUL, 32'd1234, 32'd5678);
      run(OP_MULHU, 32'h1234_5678, 32'h9ABC_DEF0);
`ifdef ALU_SEQ_DIV_EN
      run(OP_DIVU, 32'd100, 32'd7);
      chk("divu", 64'(last_res), 64'd14);
      chk("divu_lat", 64'(last_lat), 64'd33);
      run(OP_REMU, 32'd100, 32'd7);
      chk("remu", 64'(last_res), 64'd2);
      run(OP_DIVU, 32'd5, 32'd0);
      chk("divu_by0", 64'(last_res), 64'hFFFF_FFFF);
      chk("divu_by0_err", 64'(last_err), 64'd1);
      chk("divu_by0_lat", 64'(last_lat), 64'd1);
      run(OP_REMU, 32'd5, 32'd0);
      run(OP_DIVU, 32'hFFFF_FFFF, 32'd3);
`else
      run(OP_DIVU, 32'd100, 32'd7);
      chk("divu_nodiv_res", 64'(last_res), 64'd0);
      chk("divu_nodiv_err", 64'(last_err), 64'd1);
      run(OP_REMU, 32'd5, 32'd0);
`endif
      run(4'b0011, 32'd9, 32'd9);
      chk("illegal_res", 64'(last_res), 64'd0);
      chk("illegal_err", 64'(last_err), 64'd1);
      chk("illegal_zero", 64'(last_zero), 64'd1);

      // Backpressure: result held, extra issue attempts dropped.
      @(posedge clk); #1 bus.out_ready_i = 1'b0;
      issue(OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      ok = 1'b0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (bus.out_valid_o) begin ok = 1'b1; break; end
      end
      if (!ok) bound_fail("bp_valid_timeout");
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         bus.in_valid_i = (i % 2 == 0);
         bus.op_i = OP_ADD; bus.src1_i = 32'(i); bus.src2_i = 32'd1;
      end
      @(posedge clk); #1 bus.in_valid_i = 1'b0;
      @(negedge clk);
      chk("bp_valid_held", 64'(bus.out_valid_o), 64'd1);
      chk("bp_ready_low",  64'(bus.in_ready_o),  64'd0);
      @(posedge clk); #1 bus.out_ready_i = 1'b1;
      wait_done();
      chk("bp_result", 64'(last_res), 64'hFFFF_FFFE);

      // Reset in the middle of a multiply aborts it.
      issue(OP_MUL, 32'd12345, 32'd6789);
      repeat (10) @(posedge clk);
      #1 rst_n = 1'b0;
      @(posedge clk);
      @(negedge clk);
      chk("abort_valid", 64'(bus.out_valid_o), 64'd0);
      chk("abort_ready", 64'(bus.in_ready_o),  64'd1);
      chk("abort_result", 64'(bus.result_o),   64'd0);
      @(posedge clk); #1 rst_n = 1'b1;
      run(OP_MUL, 32'd3, 32'd7);
      chk("post_abort_mul", 64'(last_res), 64'd21);
      chk("post_abort_lat", 64'(last_lat), 64'd33);

      repeat (3) @(posedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
